// File: rtl/slc3_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// slc3_input_conditioner_if
//   Bundle of board-facing pins and conditioned outputs for the SLC-3 input
//   stage.
//
//   Raw pins (board -> conditioner):
//     Run_raw, Continue_raw : push buttons, 0 = pressed
//     SW_raw[SW_W-1:0]      : slide switches
//   Conditioned outputs (conditioner -> SLC-3 wiring):
//     SW_S                  : synchronised switches
//     Run_ah, Continue_ah   : debounced levels, 1 = pressed
//     Run_pulse, Continue_pulse : one-cycle press strobes
//     Reset_ah              : active-high reset request for core/test memory
//
//   Modports:
//     master : the board/testbench side (drives pins, observes outputs)
//     slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface slc3_input_conditioner_if #(
  parameter int SW_W = 10
);
  logic            Run_raw;
  logic            Continue_raw;
  logic [SW_W-1:0] SW_raw;
  logic [SW_W-1:0] SW_S;
  logic            Run_ah;
  logic            Continue_ah;
  logic            Run_pulse;
  logic            Continue_pulse;
  logic            Reset_ah;

  modport master (
    output Run_raw, Continue_raw, SW_raw,
    input  SW_S, Run_ah, Continue_ah, Run_pulse, Continue_pulse, Reset_ah
  );

  modport slave (
    input  Run_raw, Continue_raw, SW_raw,
    output SW_S, Run_ah, Continue_ah, Run_pulse, Continue_pulse, Reset_ah
  );
endinterface

// File: rtl/slc3_input_conditioner.sv
// -----------------------------------------------------------------------------
// slc3_input_conditioner
//   Board-facing input stage for the SLC-3. Synchronises the raw Run/Continue
//   buttons and slide switches, debounces the buttons, and turns them into
//   clean levels, single-cycle press strobes and a combined reset request
//   (both buttons held together).
//
//   Ports:
//     Clk   : system clock
//     Reset : asynchronous, active-low reset
//     io    : slc3_input_conditioner_if.slave (raw pins in, conditioned out)
//
//   Parameters:
//     DEBOUNCE_CYCLES : cycles a synchronised button must hold a new value
//                       before the debounced state flips (2 .. 2**CNT_W-1)
//     CNT_W           : debounce counter width
//     SW_W            : switch bus width (must match the interface)
// -----------------------------------------------------------------------------
module slc3_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int SW_W            = 10
) (
  input  logic                    Clk,
  input  logic                    Reset,
  slc3_input_conditioner_if.slave io
);

  typedef enum logic {
    ST_NORMAL,
    ST_RESETTING
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 = Run, 1 = Continue.
  logic [1:0]            btn_raw;
  logic [1:0]            btn_s1_q, btn_s1_d;   // raw level, 0 = pressed
  logic [1:0]            btn_s2_q, btn_s2_d;
  logic [SW_W-1:0]       sw_s1_q, sw_s1_d;
  logic [SW_W-1:0]       sw_s2_q, sw_s2_d;
  logic [1:0]            deb_q, deb_d;         // debounced, 1 = pressed
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                state_q, state_d;

  logic [1:0] sync_pressed;
  logic [1:0] press;
  logic       both_pressed;
  logic       both_released;
  logic [1:0] level_out;
  logic [1:0] pulse_out;
  logic       reset_req;

  assign btn_raw = {io.Continue_raw, io.Run_raw};

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  always_comb begin
    btn_s1_d = btn_raw;
    btn_s2_d = btn_s1_q;
    sw_s1_d  = io.SW_raw;
    sw_s2_d  = sw_s1_q;
  end

  // ---------------------------------------------------------------------------
  // Debouncers: the counter only runs while the synchronised value disagrees
  // with the debounced state, so any bounce back restarts the count.
  // ---------------------------------------------------------------------------
  assign sync_pressed = ~btn_s2_q;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM and output decode
  // ---------------------------------------------------------------------------
  assign press         = deb_q & ~deb_prev_q;
  assign both_pressed  = &deb_q;
  assign both_released = ~|deb_q;

  always_comb begin
    state_d   = state_q;
    level_out = '0;
    pulse_out = '0;
    reset_req = 1'b0;
    unique case (state_q)
      ST_NORMAL: begin
        level_out = deb_q;
        // The cycle the second button lands is the chord, not a press.
        if (both_pressed) begin
          state_d = ST_RESETTING;
        end else begin
          pulse_out = press;
        end
      end
      ST_RESETTING: begin
        reset_req = 1'b1;
        // Leave only once both are released; the edge detector then needs a
        // fresh released->pressed transition before anything is reported.
        if (both_released) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign io.SW_S           = sw_s2_q;
  assign io.Run_ah         = level_out[0];
  assign io.Continue_ah    = level_out[1];
  assign io.Run_pulse      = pulse_out[0];
  assign io.Continue_pulse = pulse_out[1];
  assign io.Reset_ah       = reset_req;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      btn_s1_q   <= '1;
      btn_s2_q   <= '1;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= ST_NORMAL;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

endmodule
